sequenciador_soma_nibble: RTL and testbench

//  Upstream control stage for the 4-bit adder/subtractor (somador_subtrator_4bits).

---
 rtl/ula_pkg.sv | 29 ++
 rtl/sequenciador_soma_nibble.sv | 154 +++++++++++++++
 tb/tb_sequenciador_soma_nibble.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA datapath: opcodes, sequencer state encoding
// and the initial carry selection used when an operation is accepted.
package ula_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALCULA = 2'b01,
    FIM     = 2'b10
  } estado_t;

  // SUB starts with carry 1 (A + ~B + 1); ADC/SBB take the external carry.
  function automatic logic carry_inicial(input logic [1:0] op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      OP_ADC:  c = cin;
      OP_SBB:  c = cin;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sequenciador_soma_nibble.sv
// Serialises one LARGURA-bit add/subtract onto an external 4-bit adder, one
// nibble per cycle LSB first, then presents the full result and flags.
module sequenciador_soma_nibble
  import ula_pkg::*;
#(
  parameter int LARGURA = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inicio,
  input  logic [1:0]         op,
  input  logic               cin_ext,
  input  logic [LARGURA-1:0] op_a,
  input  logic [LARGURA-1:0] op_b,
  output logic               ocupado,
  output logic               pronto,
  output logic [LARGURA-1:0] resultado,
  output logic               carry_out,
  output logic               overflow,
  output logic               zero,
  output logic [3:0]         sa_a,
  output logic [3:0]         sa_b,
  output logic               sa_modo_sub,
  output logic               sa_cin,
  input  logic [3:0]         sa_s,
  input  logic               sa_cout
);

  localparam int NIBBLES = LARGURA / 4;
  localparam int CW      = $clog2(NIBBLES);
  localparam logic [CW-1:0] ULTIMO = CW'(NIBBLES - 1);

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] a_q, a_d;
  logic [LARGURA-1:0] b_q, b_d;
  logic [LARGURA-1:0] res_q, res_d;
  logic [LARGURA-1:0] resultado_q, resultado_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               modo_q, modo_d;
  logic               carry_q, carry_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;
  logic [LARGURA-1:0] res_desloc_s;
  logic               calcula_s;

  assign res_desloc_s = {sa_s, res_q[LARGURA-1:4]};
  assign calcula_s    = (estado_q == CALCULA);

  // Next-state, operand shifting and result/flag capture
  always_comb begin
    estado_d    = estado_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    resultado_d = resultado_q;
    cnt_d       = cnt_q;
    modo_d      = modo_q;
    carry_d     = carry_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          estado_d = CALCULA;
          a_d      = op_a;
          b_d      = op_b;
          modo_d   = op[0];
          carry_d  = carry_inicial(op, cin_ext);
          cnt_d    = '0;
          a_msb_d  = op_a[LARGURA-1];
          b_msb_d  = op_b[LARGURA-1];
        end else begin
          estado_d = OCIOSO;
        end
      end
      CALCULA: begin
        a_d     = {4'd0, a_q[LARGURA-1:4]};
        b_d     = {4'd0, b_q[LARGURA-1:4]};
        res_d   = res_desloc_s;
        carry_d = sa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == ULTIMO) begin
          estado_d    = FIM;
          resultado_d = res_desloc_s;
          carry_out_d = sa_cout;
          // MSBs were shifted out of a_q/b_q, hence the dedicated registers
          overflow_d  = (a_msb_q == (b_msb_q ^ modo_q)) & (sa_s[3] != a_msb_q);
          zero_d      = (res_desloc_s == '0);
        end else begin
          estado_d = CALCULA;
        end
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      resultado_q <= '0;
      cnt_q       <= '0;
      modo_q      <= 1'b0;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      resultado_q <= resultado_d;
      cnt_q       <= cnt_d;
      modo_q      <= modo_d;
      carry_q     <= carry_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  // Adder side is quiet outside CALCULA
  assign sa_a        = calcula_s ? a_q[3:0] : 4'd0;
  assign sa_b        = calcula_s ? b_q[3:0] : 4'd0;
  assign sa_modo_sub = calcula_s ? modo_q   : 1'b0;
  assign sa_cin      = calcula_s ? carry_q  : 1'b0;

  assign ocupado   = calcula_s;
  assign pronto    = (estado_q == FIM);
  assign resultado = resultado_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sequenciador_soma_nibble.sv
// Directed table-driven bench for the nibble sequencer with a behavioural
// 4-bit adder/subtractor closing the loop on the sa_* ports.
module tb_sequenciador_soma_nibble;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic [1:0]  op;
  logic        cin_ext;
  logic [15:0] op_a, op_b;
  logic        ocupado, pronto, carry_out, overflow, zero;
  logic [15:0] resultado;
  logic [3:0]  sa_a, sa_b, sa_s;
  logic        sa_modo_sub, sa_cin, sa_cout;
  logic [4:0]  soma_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        ov;
    logic        z;
  } vetor_t;

  vetor_t tab[10];

  always #5 clk = ~clk;

  // adder inverts B itself when subtracting
  assign soma_s  = {1'b0, sa_a} + {1'b0, (sa_b ^ {4{sa_modo_sub}})} + {4'd0, sa_cin};
  assign sa_s    = soma_s[3:0];
  assign sa_cout = soma_s[4];

  sequenciador_soma_nibble #(.LARGURA(16)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .op(op), .cin_ext(cin_ext),
    .op_a(op_a), .op_b(op_b), .ocupado(ocupado), .pronto(pronto),
    .resultado(resultado), .carry_out(carry_out), .overflow(overflow), .zero(zero),
    .sa_a(sa_a), .sa_b(sa_b), .sa_modo_sub(sa_modo_sub), .sa_cin(sa_cin),
    .sa_s(sa_s), .sa_cout(sa_cout)
  );

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nome, got, exp);
    end
  endtask

  task automatic ciclo();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input vetor_t v, input logic [3:0] cin0);
    int lat;
    @(negedge clk);
    inicio = 1'b1; op = v.op; cin_ext = v.cin; op_a = v.a; op_b = v.b;
    ciclo();
    inicio = 1'b0; op = ~v.op; cin_ext = ~v.cin; op_a = ~v.a; op_b = ~v.b;
    chk("ocupado_calc", {31'd0, ocupado}, 32'd1);
    chk("sa_a_n0", {28'd0, sa_a}, {28'd0, v.a[3:0]});
    chk("sa_b_n0", {28'd0, sa_b}, {28'd0, v.b[3:0]});
    chk("sa_modo", {31'd0, sa_modo_sub}, {31'd0, v.op[0]});
    chk("sa_cin_n0", {28'd0, sa_cin}, {28'd0, cin0});
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      if (n > 1) ciclo();
      if (pronto) lat = n;
    end
    chk("latencia", lat, 32'd5);
    chk("ocupado_fim", {31'd0, ocupado}, 32'd0);
    chk("resultado", {16'd0, resultado}, {16'd0, v.res});
    chk("carry_out", {31'd0, carry_out}, {31'd0, v.c});
    chk("overflow", {31'd0, overflow}, {31'd0, v.ov});
    chk("zero", {31'd0, zero}, {31'd0, v.z});
    chk("sa_fim", {23'd0, sa_a, sa_b, sa_cin}, 32'd0);
    ciclo();
    chk("pronto_pulso", {31'd0, pronto}, 32'd0);
    chk("resultado_held", {16'd0, resultado}, {16'd0, v.res});
  endtask

  initial begin
    int np;
    int t_pronto[$];
    logic [15:0] r_pronto[$];

    tab[0] = '{2'b00, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0};
    tab[1] = '{2'b01, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tab[2] = '{2'b00, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    tab[3] = '{2'b10, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0};
    tab[4] = '{2'b11, 1'b0, 16'h0005, 16'h0003, 16'h0001, 1'b1, 1'b0, 1'b0};
    tab[5] = '{2'b01, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tab[6] = '{2'b01, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
    tab[7] = '{2'b00, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    tab[8] = '{2'b11, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
    tab[9] = '{2'b10, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; inicio = 1'b0; op = 2'b00; cin_ext = 1'b0; op_a = 16'd0; op_b = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {10'd0, ocupado, pronto, resultado, carry_out, overflow, zero}, 32'd0);
    chk("reset_sa", {22'd0, sa_a, sa_b, sa_modo_sub, sa_cin}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(tab[i], (tab[i].op == 2'b01) ? 4'd1 : ((tab[i].op[1]) ? {3'd0, tab[i].cin} : 4'd0));
    end

    // inicio held through the whole operation with changing operands
    @(negedge clk);
    inicio = 1'b1; op = 2'b00; op_a = 16'h0001; op_b = 16'h0001;
    np = 0;
    for (int n = 1; n <= 16; n++) begin
      ciclo();
      if (n == 2) begin op_a = 16'h0100; op_b = 16'h0200; end
      if (n == 7) inicio = 1'b0;
      if (ocupado && pronto) chk("ocupado_e_pronto", 32'd1, 32'd0);
      if (pronto) begin
        np++;
        t_pronto.push_back(n);
        r_pronto.push_back(resultado);
      end
    end
    chk("hold_num_pronto", np, 32'd2);
    if (np == 2) begin
      chk("hold_t1", t_pronto[0], 32'd5);
      chk("hold_r1", {16'd0, r_pronto[0]}, 32'h0002);
      chk("hold_t2", t_pronto[1], 32'd11);
      chk("hold_r2", {16'd0, r_pronto[1]}, 32'h0300);
    end

    // reset during the second CALCULA cycle
    @(negedge clk);
    inicio = 1'b1; op = 2'b00; op_a = 16'h4321; op_b = 16'h1111;
    ciclo();
    inicio = 1'b0;
    ciclo();
    chk("pre_rst_ocupado", {31'd0, ocupado}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_out", {10'd0, ocupado, pronto, resultado, carry_out, overflow, zero}, 32'd0);
    chk("rst_sa", {22'd0, sa_a, sa_b, sa_modo_sub, sa_cin}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    np = 0;
    for (int n = 0; n < 8; n++) begin
      ciclo();
      if (pronto || ocupado) np++;
    end
    chk("rst_sem_pronto", np, 32'd0);
    run_op('{2'b00, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0}, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
